// File: rtl/result_hex_tx_if.sv
// result_hex_tx_if
//   Bundles the result/handshake signals around result_hex_tx.
//   master : the hex transmitter (consumes result/alu_done/tx_ready,
//            drives tx_data/tx_valid/busy/tx_done)
//   slave  : the environment (multiplier + UART side)
//   result    32  multiplier product, valid while alu_done is high
//   alu_done  1   level from multiplier, rises once per operation
//   tx_ready  1   UART can accept a byte this cycle
//   tx_data   8   ASCII byte offered to the UART
//   tx_valid  1   tx_data is valid
//   busy      1   transmitter is sending a result
//   tx_done   1   one-cycle pulse after the final byte
interface result_hex_tx_if;
   logic [31:0] result;
   logic        alu_done;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        tx_done;

   modport master (
      input  result, alu_done, tx_ready,
      output tx_data, tx_valid, busy, tx_done
   );

   modport slave (
      output result, alu_done, tx_ready,
      input  tx_data, tx_valid, busy, tx_done
   );
endinterface

// File: rtl/result_hex_tx.sv
// result_hex_tx
//   Converts a 32-bit multiplier result into ASCII hex (MSB nibble first),
//   optionally followed by CR LF, and streams it byte by byte to a UART
//   through a valid/ready handshake. A transmission starts on a rising edge
//   of alu_done seen while idle.
// Parameters
//   SEND_CRLF  1: append 0x0D 0x0A after the eight digits, 0: digits only
//   UPPERCASE  1: digits A-F as 0x41-0x46, 0: as 0x61-0x66
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   result_hex_tx_if.master (result, alu_done, tx_ready in;
//         tx_data, tx_valid, busy, tx_done out)
module result_hex_tx #(
   parameter int SEND_CRLF = 1,
   parameter int UPPERCASE = 1
) (
   input  logic            clk,
   input  logic            rst,
   result_hex_tx_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = (SEND_CRLF != 0) ? 4'd9 : 4'd7;

   state_t      state;
   state_t      state_nxt;
   logic        done_d;
   logic [31:0] hold;
   logic [3:0]  idx;
   logic        start;
   logic        xfer;
   logic        last_xfer;
   logic [31:0] hold_sh;
   logic [7:0]  char_cur;

   // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10)
         c = 8'h30 + {4'h0, nib};
      else if (UPPERCASE != 0)
         c = 8'h37 + {4'h0, nib};
      else
         c = 8'h57 + {4'h0, nib};
      return c;
   endfunction

   always_comb begin
      start     = (state == IDLE) && bus.alu_done && !done_d;
      xfer      = (state == SEND) && bus.tx_ready;
      last_xfer = xfer && (idx == LAST_IDX);
   end

   // Shifting the selected nibble to the top keeps the mux index-driven
   // without a variable part-select.
   always_comb begin
      hold_sh  = hold << {idx[2:0], 2'b00};
      char_cur = 8'h0A;
      if (idx < 4'd8)
         char_cur = hex_char(hold_sh[31:28]);
      else if (idx == 4'd8)
         char_cur = 8'h0D;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SEND;
         SEND:    if (last_xfer) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // done_d resets high so a level already present at reset release is
   // not mistaken for a new operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         done_d <= 1'b1;
      else
         done_d <= bus.alu_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
         idx  <= '0;
      end else if (start) begin
         hold <= bus.result;
         idx  <= '0;
      end else if (last_xfer) begin
         idx  <= '0;
      end else if (xfer) begin
         idx  <= idx + 4'd1;
      end
   end

   // Outputs decode straight from state so reset drops tx_valid at once.
   assign bus.tx_valid = (state == SEND);
   assign bus.tx_data  = (state == SEND) ? char_cur : 8'h00;
   assign bus.busy     = (state != IDLE);
   assign bus.tx_done  = (state == FIN);

endmodule

// File: tb/tb_result_hex_tx.sv
`timescale 1ns/1ps
module tb_result_hex_tx;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   result_hex_tx_if if_a ();
   result_hex_tx_if if_b ();

   result_hex_tx #(.SEND_CRLF(1), .UPPERCASE(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.master)
   );

   result_hex_tx #(.SEND_CRLF(0), .UPPERCASE(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.master)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];

   task automatic push_expected(input logic [31:0] val, input bit upper, input bit crlf);
      string dig;
      dig = upper ? "0123456789ABCDEF" : "0123456789abcdef";
      for (int i = 7; i >= 0; i--)
         exp_q.push_back(dig[val[i*4 +: 4]]);
      if (crlf) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_a.result = '0;  if_a.alu_done = 1'b1; if_a.tx_ready = 1'b1;
      if_b.result = '0;  if_b.alu_done = 1'b1; if_b.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.tx_done !== 1'b0 || if_a.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_a: valid=%b busy=%b done=%b data=%h, expected 0 0 0 00",
                  if_a.tx_valid, if_a.busy, if_a.tx_done, if_a.tx_data);
      end
      n_tests++;
      if (if_b.tx_valid !== 1'b0 || if_b.busy !== 1'b0 || if_b.tx_done !== 1'b0 || if_b.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_b: valid=%b busy=%b done=%b data=%h, expected 0 0 0 00",
                  if_b.tx_valid, if_b.busy, if_b.tx_done, if_b.tx_data);
      end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_tests++;
         if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b0 || if_b.tx_valid !== 1'b0 || if_b.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_start_after_reset c%0d: a valid=%b busy=%b b valid=%b busy=%b, expected all 0",
                     c, if_a.tx_valid, if_a.busy, if_b.tx_valid, if_b.busy);
         end
      end
      next_cycle();
      if_a.alu_done = 1'b0;
      if_b.alu_done = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_deadbeef();
      logic [7:0] exp;
      exp_q.delete();
      push_expected(32'hDEADBEEF, 1'b1, 1'b1);
      if_a.result   = 32'hDEADBEEF;
      if_a.tx_ready = 1'b1;
      if_a.alu_done = 1'b1;
      @(negedge clk);
      n_tests++;
      if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL deadbeef_start_cycle: valid=%b busy=%b, expected 0 0", if_a.tx_valid, if_a.busy);
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_tests++;
         if (k <= 10) begin
            exp = exp_q.pop_front();
            if (if_a.tx_valid !== 1'b1 || if_a.tx_data !== exp || if_a.busy !== 1'b1 || if_a.tx_done !== 1'b0) begin
               n_fail++;
               $display("FAIL deadbeef_byte N+%0d: valid=%b data=%h busy=%b done=%b, expected 1 %h 1 0",
                        k, if_a.tx_valid, if_a.tx_data, if_a.busy, if_a.tx_done, exp);
            end
         end else if (k == 11) begin
            if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b1 || if_a.tx_done !== 1'b1) begin
               n_fail++;
               $display("FAIL deadbeef_done N+11: valid=%b busy=%b done=%b, expected 0 1 1",
                        if_a.tx_valid, if_a.busy, if_a.tx_done);
            end
         end else begin
            if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.tx_done !== 1'b0) begin
               n_fail++;
               $display("FAIL deadbeef_idle N+12: valid=%b busy=%b done=%b, expected 0 0 0",
                        if_a.tx_valid, if_a.busy, if_a.tx_done);
            end
         end
      end
      next_cycle();
   endtask

   task automatic test_ready_toggle();
      logic [7:0] exp;
      logic [3:0] pat;
      int         nx;
      bit         seen_done;
      pat = 4'b1001;
      if_a.alu_done = 1'b0;
      next_cycle();
      next_cycle();
      exp_q.delete();
      push_expected(32'h00000000, 1'b1, 1'b1);
      if_a.result   = 32'h00000000;
      if_a.alu_done = 1'b1;
      nx = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 80 && !seen_done; c++) begin
         if_a.tx_ready = pat[c[1:0]];
         @(negedge clk);
         if (if_a.tx_done === 1'b1) seen_done = 1'b1;
         if (if_a.tx_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL toggle_extra_byte c%0d: data=%h, expected no byte", c, if_a.tx_data);
            end else if (if_a.tx_ready === 1'b1) begin
               exp = exp_q.pop_front();
               nx++;
               if (if_a.tx_data !== exp) begin
                  n_fail++;
                  $display("FAIL toggle_byte c%0d: data=%h, expected %h", c, if_a.tx_data, exp);
               end
            end else if (if_a.tx_data !== exp_q[0]) begin
               n_fail++;
               $display("FAIL toggle_stable c%0d: data=%h, expected %h held", c, if_a.tx_data, exp_q[0]);
            end
         end
         next_cycle();
      end
      if_a.tx_ready = 1'b1;
      n_tests++;
      if (nx !== 10) begin
         n_fail++;
         $display("FAIL toggle_count: transfers=%0d, expected 10", nx);
      end
      n_tests++;
      if (!seen_done) begin
         n_fail++;
         $display("FAIL toggle_done: tx_done seen=%0d, expected 1", seen_done);
      end
   endtask

   task automatic test_lower_nocrlf();
      logic [7:0] exp;
      int         nx;
      int         last_c;
      int         done_c;
      exp_q.delete();
      push_expected(32'h0123ABCF, 1'b0, 1'b0);
      if_b.result   = 32'h0123ABCF;
      if_b.tx_ready = 1'b1;
      if_b.alu_done = 1'b1;
      nx = 0;
      last_c = -1;
      done_c = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (if_b.tx_done === 1'b1 && done_c < 0) done_c = c;
         if (if_b.tx_valid === 1'b1 && if_b.tx_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL lower_extra_byte c%0d: data=%h, expected no byte", c, if_b.tx_data);
            end else begin
               exp = exp_q.pop_front();
               nx++;
               last_c = c;
               if (if_b.tx_data !== exp) begin
                  n_fail++;
                  $display("FAIL lower_byte c%0d: data=%h, expected %h", c, if_b.tx_data, exp);
               end
            end
         end
         next_cycle();
      end
      n_tests++;
      if (nx !== 8) begin
         n_fail++;
         $display("FAIL lower_count: transfers=%0d, expected 8", nx);
      end
      n_tests++;
      if (done_c !== last_c + 1 || last_c < 0) begin
         n_fail++;
         $display("FAIL lower_done_timing: done at c%0d, expected c%0d", done_c, last_c + 1);
      end
   endtask

   task automatic test_retrigger();
      logic [7:0] exp;
      int         nx;
      int         n_done;
      if_a.alu_done = 1'b0;
      next_cycle();
      next_cycle();
      exp_q.delete();
      push_expected(32'h11111111, 1'b1, 1'b1);
      if_a.result   = 32'h11111111;
      if_a.tx_ready = 1'b1;
      if_a.alu_done = 1'b1;
      nx = 0;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (if_a.tx_done === 1'b1) n_done++;
         if (if_a.tx_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL retrig_extra_byte c%0d: data=%h, expected no byte", c, if_a.tx_data);
            end else begin
               exp = exp_q.pop_front();
               nx++;
               if (if_a.tx_data !== exp) begin
                  n_fail++;
                  $display("FAIL retrig_byte c%0d: data=%h, expected %h", c, if_a.tx_data, exp);
               end
            end
         end
         next_cycle();
         if (c == 3) if_a.alu_done = 1'b0;
         if (c == 4) if_a.result = 32'h22222222;
         if (c == 5) if_a.alu_done = 1'b1;
      end
      n_tests++;
      if (nx !== 10 || n_done !== 1) begin
         n_fail++;
         $display("FAIL retrig_summary: transfers=%0d done_pulses=%0d, expected 10 1", nx, n_done);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] exp;
      int         nx;
      int         stray;
      bit         seen_done;
      if_a.alu_done = 1'b0;
      next_cycle();
      next_cycle();
      exp_q.delete();
      push_expected(32'hCAFEF00D, 1'b1, 1'b1);
      if_a.result   = 32'hCAFEF00D;
      if_a.tx_ready = 1'b1;
      if_a.alu_done = 1'b1;
      nx = 0;
      for (int c = 0; c < 20 && nx < 3; c++) begin
         @(negedge clk);
         if (if_a.tx_valid === 1'b1 && if_a.tx_ready === 1'b1) begin
            exp = exp_q.pop_front();
            nx++;
            n_tests++;
            if (if_a.tx_data !== exp) begin
               n_fail++;
               $display("FAIL abort_byte %0d: data=%h, expected %h", nx, if_a.tx_data, exp);
            end
         end
         next_cycle();
      end
      @(negedge clk);
      n_tests++;
      if (if_a.tx_valid !== 1'b1 || if_a.tx_data !== 8'h45) begin
         n_fail++;
         $display("FAIL abort_fourth_offer: valid=%b data=%h, expected 1 45", if_a.tx_valid, if_a.tx_data);
      end
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if (if_a.tx_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.tx_data !== 8'h00 || if_a.tx_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_immediate: valid=%b busy=%b data=%h done=%b, expected 0 0 00 0",
                  if_a.tx_valid, if_a.busy, if_a.tx_data, if_a.tx_done);
      end
      stray = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (if_a.tx_valid !== 1'b0 || if_a.tx_done !== 1'b0) stray++;
      end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (if_a.tx_valid !== 1'b0 || if_a.tx_done !== 1'b0 || if_a.busy !== 1'b0) stray++;
      end
      n_tests++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL abort_quiet: stray active cycles=%0d, expected 0", stray);
      end
      next_cycle();
      if_a.alu_done = 1'b0;
      next_cycle();
      exp_q.delete();
      push_expected(32'h00000005, 1'b1, 1'b1);
      if_a.result   = 32'h00000005;
      if_a.alu_done = 1'b1;
      nx = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if_a.tx_done === 1'b1) seen_done = 1'b1;
         if (if_a.tx_valid === 1'b1 && if_a.tx_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL restart_extra_byte c%0d: data=%h, expected no byte", c, if_a.tx_data);
            end else begin
               exp = exp_q.pop_front();
               nx++;
               if (if_a.tx_data !== exp) begin
                  n_fail++;
                  $display("FAIL restart_byte c%0d: data=%h, expected %h", c, if_a.tx_data, exp);
               end
            end
         end
         next_cycle();
      end
      n_tests++;
      if (nx !== 10 || !seen_done) begin
         n_fail++;
         $display("FAIL restart_summary: transfers=%0d done=%0d, expected 10 1", nx, seen_done);
      end
   endtask

   initial begin
      test_reset();
      test_deadbeef();
      test_ready_toggle();
      test_lower_nocrlf();
      test_retrigger();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
